ram_bist_ctrl: RTL and testbench
================================

Name: ram_bist_ctrl

Overview:
Built-in self-test initiator for the team's single-port synchronous RAM (ram_simple); it sits on the RAM's clk/we/addr/data_in/data_out interface.
On a start pulse it runs a two-pass write/read-back march over the whole address space, comparing every read word against the expected pattern.
It reports pass/fail, an error count and first-failure details.
It is the initiator for the RAM, and all RAM traffic during test originates here.

Parameters:
DATA_WIDTH, 8, RAM word width in bits
ADDR_WIDTH, 8, RAM address width; DEPTH = 2**ADDR_WIDTH words tested
RD_LATENCY, 1, cycles from address presented to valid mem_rdata; legal 1..4

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a test; honoured only in IDLE
seed  input  DATA_WIDTH  pattern seed, sampled on accepted start
mem_we  output  1  RAM write enable
mem_addr  output  ADDR_WIDTH  RAM address
mem_wdata  output  DATA_WIDTH  RAM write data
mem_rdata  input  DATA_WIDTH  RAM read data (RAM data_out)
busy  output  1  high from start acceptance until DONE
done  output  1  one-cycle pulse at end of test
fail  output  1  sticky: at least one miscompare in last test
err_count  output  ADDR_WIDTH+2  number of miscompares in last test
fail_addr  output  ADDR_WIDTH  address of first miscompare
fail_exp  output  DATA_WIDTH  expected word at first miscompare
fail_got  output  DATA_WIDTH  read word at first miscompare

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, fail=0, err_count=0, fail_addr/exp/got=0.
- All outputs are registered; no combinational path from any input to any output.
- Pattern: P(a) = zero-extended/truncated a[DATA_WIDTH-1:0] XOR seed_q. Pass 0 uses P(a); pass 1 uses ~P(a).
- FSM: IDLE -> W0 -> R0 -> D0 -> W1 -> R1 -> D1 -> DONE -> IDLE.
- IDLE: start=1 at an edge latches seed_q, clears fail, err_count and fail_* in that same edge, sets busy=1, and enters W0 with the address counter at 0.
- Wn: each cycle drives mem_we=1, mem_addr=a, mem_wdata=pattern(a), a=0..DEPTH-1 ascending; exactly DEPTH cycles.
- Rn: mem_we=0, mem_addr=a ascending 0..DEPTH-1, DEPTH cycles; mem_wdata held at 0.
- Read alignment: expected word and address go down a RD_LATENCY-deep valid/addr/exp shift pipe. mem_rdata is compared when the pipe output is valid.
- Dn: drain for RD_LATENCY cycles, issuing no new reads, so the last compare of the pass completes.
- Miscompare handling:
  - err_count increments by 1. It is wide enough for 2*DEPTH errors and never wraps.
  - The first miscompare of a test (err_count==0 before the increment) captures fail_addr/fail_exp/fail_got.
  - fail goes high the next edge and stays high.
- DONE: exactly one cycle; done=1, busy=0 on the following edge, and the FSM returns to IDLE.
- Latency: start accepted at edge k; done is high in the cycle after edge k + 2*(2*DEPTH+RD_LATENCY).
- Result outputs hold until the next accepted start or reset.
- start while busy (any non-IDLE state) is ignored; it has no effect on seed_q or results.
- start in the DONE cycle is ignored; start is accepted in IDLE on the next cycle.
- Address counter wraps DEPTH-1 -> 0 only at a state change, never mid-pass.
- rst_n low mid-test aborts immediately and drives mem_we=0 asynchronously. Any RAM contents already written are left as is.

Test Plan:
- Run 1, fault-free RAM, DATA_WIDTH=8, ADDR_WIDTH=4, RD_LATENCY=1:
  - Stimulus: seed=8'h5A, start pulse.
  - Response: done 66 cycles after acceptance; fail=0, err_count=0.
  - During W0, mem_wdata at addr 3 = 8'h59; during W1, addr 3 = 8'hA6.
- Run 2, stuck-at-0 on bit 0 at RAM address 5 (same config): seed=8'h00, start.
  - Pass 0 expects 8'h05 and gets 8'h04; pass 1 expects 8'hFA, which already has bit 0 = 0, so it passes.
  - Response: fail=1, err_count=1, fail_addr=5, fail_exp=8'h05, fail_got=8'h04.
- Run 3: start re-pulsed at cycles 10 and 40 of a running test -> no restart; done at exactly cycle 66; busy continuous.
- Run 4: rst_n=0 asserted mid-R0 (cycle 20) -> mem_we, busy, fail, err_count all 0 before the next clk edge. A fresh start after release completes normally in 66 cycles.
- Run 5, RD_LATENCY=2 with a 2-cycle RAM model, fault-free, seed=8'hFF:
  - Response: done 68 cycles after start; err_count=0.
  - The same run with RD_LATENCY=1 against the 2-cycle model must report fail=1.
- Run 6: back-to-back tests, second with a fault (stuck-at-1 bit 7, all addresses) -> first test results cleared at the second start.
  - Second test final err_count=16. Bit 7 of P(a) is 0 in pass 0 for all 16 addresses and 1 in pass 1.
  - fail_addr=0, fail_exp=8'h00 with seed=8'h00, fail_got=8'h80.

Source files
------------

// File: rtl/ram_bist_if.sv
// RAM-side bus between the BIST controller and a single-port synchronous RAM.
// The controller is the master: it drives address, write enable and write data.
interface ram_bist_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
    modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/ram_bist_ctrl.sv
// Two-pass write/read-back march BIST for a single-port synchronous RAM.
// Reports pass/fail, a saturating error count and first-miscompare details.
module ram_bist_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    ram_bist_if.master            ram,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_WIDTH+1:0] err_count,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_got
);
    localparam int                  CW         = ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
    localparam logic [CW-1:0]       ERR_MAX    = {CW{1'b1}};
    localparam logic [2:0]          DRAIN_LAST = 3'(RD_LATENCY - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_W0   = 3'd1;
    localparam logic [2:0] ST_R0   = 3'd2;
    localparam logic [2:0] ST_D0   = 3'd3;
    localparam logic [2:0] ST_W1   = 3'd4;
    localparam logic [2:0] ST_R1   = 3'd5;
    localparam logic [2:0] ST_D1   = 3'd6;
    localparam logic [2:0] ST_DONE = 3'd7;

    // Address zero-extended/truncated to the word width, XOR seed, inverted on pass 1.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] s,
                                                      input logic                  inv);
        logic [DATA_WIDTH+ADDR_WIDTH-1:0] wide;
        logic [DATA_WIDTH-1:0]            p;
        wide = {{DATA_WIDTH{1'b0}}, a};
        p    = wide[DATA_WIDTH-1:0] ^ s;
        return inv ? ~p : p;
    endfunction

    logic [2:0]            st_r, st_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_s;
    logic [2:0]            drain_r, drain_s;
    logic                  accept_s, wr_s, rd_s, inv_s, miss_s;
    logic [DATA_WIDTH-1:0] seed_q_r, seed_s, pat_s;

    logic                  mem_we_r, rd_r, busy_r, done_r, fail_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r, fail_addr_r;
    logic [DATA_WIDTH-1:0] mem_wdata_r, exp_r, fail_exp_r, fail_got_r;
    logic [CW-1:0]         err_count_r;

    logic [RD_LATENCY-1:0] pv_r;
    logic [ADDR_WIDTH-1:0] pa_r [RD_LATENCY];
    logic [DATA_WIDTH-1:0] pe_r [RD_LATENCY];

    // Next-state, address counter and drain counter.
    always_comb begin
        st_s     = st_r;
        addr_s   = addr_r;
        drain_s  = drain_r;
        accept_s = 1'b0;
        case (st_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
                    st_s     = ST_W0;
                    addr_s   = '0;
                end else begin
                    st_s = ST_IDLE;
                end
            end
            ST_W0, ST_R0, ST_W1, ST_R1: begin
                if (addr_r == ADDR_MAX) begin
                    st_s    = st_r + 3'd1;
                    addr_s  = '0;
                    drain_s = 3'd0;
                end else begin
                    addr_s = addr_r + ADDR_WIDTH'(1'b1);
                end
            end
            ST_D0, ST_D1: begin
                if (drain_r == DRAIN_LAST) begin
                    st_s = st_r + 3'd1;
                end else begin
                    drain_s = drain_r + 3'd1;
                end
            end
            ST_DONE: st_s = ST_IDLE;
            default: st_s = ST_IDLE;
        endcase
    end

    // Bus values for the upcoming cycle, so every output can be registered.
    always_comb begin
        seed_s = accept_s ? seed : seed_q_r;
        wr_s   = (st_s == ST_W0) || (st_s == ST_W1);
        rd_s   = (st_s == ST_R0) || (st_s == ST_R1);
        inv_s  = (st_s == ST_W1) || (st_s == ST_R1);
        pat_s  = pattern(addr_s, seed_s, inv_s);
        miss_s = pv_r[RD_LATENCY-1] && (ram.mem_rdata != pe_r[RD_LATENCY-1]);
    end

    // FSM state and registered RAM bus / status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_r        <= ST_IDLE;
            addr_r      <= '0;
            drain_r     <= 3'd0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            rd_r        <= 1'b0;
            exp_r       <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            st_r        <= st_s;
            addr_r      <= addr_s;
            drain_r     <= drain_s;
            mem_we_r    <= wr_s;
            mem_addr_r  <= addr_s;
            mem_wdata_r <= wr_s ? pat_s : '0;
            rd_r        <= rd_s;
            exp_r       <= rd_s ? pat_s : '0;
            busy_r      <= (st_s != ST_IDLE) && (st_s != ST_DONE);
            done_r      <= (st_s == ST_DONE);
        end
    end

    // Read-alignment pipe: stage RD_LATENCY-1 lines up with mem_rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv_r <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pa_r[i] <= '0;
                pe_r[i] <= '0;
            end
        end else begin
            pv_r[0] <= rd_r;
            pa_r[0] <= mem_addr_r;
            pe_r[0] <= exp_r;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv_r[i] <= pv_r[i-1];
                pa_r[i] <= pa_r[i-1];
                pe_r[i] <= pe_r[i-1];
            end
        end
    end

    // Seed capture and result bookkeeping; a new start clears the previous results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_q_r    <= '0;
            fail_r      <= 1'b0;
            err_count_r <= '0;
            fail_addr_r <= '0;
            fail_exp_r  <= '0;
            fail_got_r  <= '0;
        end else if (accept_s) begin
            seed_q_r    <= seed;
            fail_r      <= 1'b0;
            err_count_r <= '0;
            fail_addr_r <= '0;
            fail_exp_r  <= '0;
            fail_got_r  <= '0;
        end else if (miss_s) begin
            fail_r <= 1'b1;
            if (err_count_r == '0) begin
                fail_addr_r <= pa_r[RD_LATENCY-1];
                fail_exp_r  <= pe_r[RD_LATENCY-1];
                fail_got_r  <= ram.mem_rdata;
            end
            if (err_count_r != ERR_MAX) begin
                err_count_r <= err_count_r + CW'(1'b1);
            end
        end
    end

    assign ram.mem_we    = mem_we_r;
    assign ram.mem_addr  = mem_addr_r;
    assign ram.mem_wdata = mem_wdata_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign fail          = fail_r;
    assign err_count     = err_count_r;
    assign fail_addr     = fail_addr_r;
    assign fail_exp      = fail_exp_r;
    assign fail_got      = fail_got_r;
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl: behavioural RAM models with fault
// injection, and a march-level reference model of the expected results.
module tb_ram_bist_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start1, start2;
    logic [DW-1:0] seed1, seed2;
    logic busy1, done1, fail1, busy2, done2, fail2;
    logic [AW+1:0] err1, err2;
    logic [AW-1:0] fa1, fa2;
    logic [DW-1:0] fe1, fg1, fe2, fg2;

    ram_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();
    ram_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if2 ();

    ram_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .seed(seed1), .ram(if1),
        .busy(busy1), .done(done1), .fail(fail1), .err_count(err1),
        .fail_addr(fa1), .fail_exp(fe1), .fail_got(fg1));

    ram_bist_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .seed(seed2), .ram(if2),
        .busy(busy2), .done(done2), .fail(fail2), .err_count(err2),
        .fail_addr(fa2), .fail_exp(fe2), .fail_got(fg2));

    // RAM 1: selectable 1- or 2-cycle read latency, per-address stuck-at masks
    logic [DW-1:0] ram1 [DEPTH];
    logic [DW-1:0] sa0 [DEPTH];
    logic [DW-1:0] sa1 [DEPTH];
    logic [DW-1:0] r1a, r1b;
    int lat1;
    always @(posedge clk) begin
        if (if1.mem_we === 1'b1)
            ram1[if1.mem_addr] <= (if1.mem_wdata & ~sa0[if1.mem_addr]) | sa1[if1.mem_addr];
        r1a <= ram1[if1.mem_addr];
        r1b <= r1a;
    end
    assign if1.mem_rdata = (lat1 == 2) ? r1b : r1a;

    // RAM 2: fault-free, fixed 2-cycle read latency
    logic [DW-1:0] ram2 [DEPTH];
    logic [DW-1:0] r2a, r2b;
    always @(posedge clk) begin
        if (if2.mem_we === 1'b1) ram2[if2.mem_addr] <= if2.mem_wdata;
        r2a <= ram2[if2.mem_addr];
        r2b <= r2a;
    end
    assign if2.mem_rdata = r2b;

    bit sel2;
    logic busy_s, done_s, fail_s;
    logic [AW+1:0] err_s;
    logic [AW-1:0] fa_s;
    logic [DW-1:0] fe_s, fg_s;
    assign busy_s = sel2 ? busy2 : busy1;
    assign done_s = sel2 ? done2 : done1;
    assign fail_s = sel2 ? fail2 : fail1;
    assign err_s  = sel2 ? err2 : err1;
    assign fa_s   = sel2 ? fa2 : fa1;
    assign fe_s   = sel2 ? fe2 : fe1;
    assign fg_s   = sel2 ? fg2 : fg1;

    int n_tests = 0;
    int n_fail = 0;

    int r_lat, wn;
    bit r_busy_gap;
    logic r_busy_at_done, r_fail, r_fail1;
    logic [AW+1:0] r_err, r_err1;
    logic [AW-1:0] r_fa;
    logic [DW-1:0] r_fe, r_fg;
    logic [AW+DW-1:0] wlog [64];

    int m_err;
    logic [AW-1:0] m_fa;
    logic [DW-1:0] m_fe, m_fg;

    logic ab_pre_we, ab_pre_fail, ab_we, ab_busy, ab_fail;
    logic [AW+1:0] ab_pre_err, ab_err;

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            sa0[i] = '0;
            sa1[i] = '0;
        end
    endtask

    // Reference: walk both passes, compare what a faulty cell would hold.
    task automatic model(input logic [DW-1:0] sd);
        logic [DW-1:0] e, g;
        m_err = 0; m_fa = '0; m_fe = '0; m_fg = '0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < DEPTH; a++) begin
                e = DW'(a) ^ sd;
                if (p == 1) e = ~e;
                g = (e & ~sa0[a]) | sa1[a];
                if (g !== e) begin
                    if (m_err == 0) begin m_fa = AW'(a); m_fe = e; m_fg = g; end
                    m_err++;
                end
            end
        end
    endtask

    task automatic run_bist(input logic [DW-1:0] sd, input bit on2, input bit repulse);
        int cyc;
        sel2 = on2;
        @(negedge clk);
        if (on2) begin start2 = 1'b1; seed2 = sd; end
        else begin start1 = 1'b1; seed1 = sd; end
        wn = 0;
        r_busy_gap = 0;
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        cyc = 1;
        r_err1 = err_s;
        r_fail1 = fail_s;
        while (done_s !== 1'b1 && cyc < 400) begin
            if (!on2 && if1.mem_we === 1'b1 && wn < 64) begin
                wlog[wn] = {if1.mem_addr, if1.mem_wdata};
                wn++;
            end
            if (busy_s !== 1'b1) r_busy_gap = 1;
            if (repulse && (cyc == 10 || cyc == 40)) begin
                if (on2) begin start2 = 1'b1; seed2 = ~sd; end
                else begin start1 = 1'b1; seed1 = ~sd; end
            end else begin
                start1 = 1'b0; start2 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start1 = 1'b0; start2 = 1'b0;
        r_lat = (done_s === 1'b1) ? cyc - 1 : -1;
        r_busy_at_done = busy_s;
        r_fail = fail_s; r_err = err_s; r_fa = fa_s; r_fe = fe_s; r_fg = fg_s;
    endtask

    task automatic abort_run(input logic [DW-1:0] sd, input int at);
        sel2 = 1'b0;
        @(negedge clk);
        start1 = 1'b1; seed1 = sd;
        @(negedge clk);
        start1 = 1'b0;
        repeat (at - 1) @(negedge clk);
        ab_pre_we = if1.mem_we; ab_pre_err = err1; ab_pre_fail = fail1;
        #2 rst_n = 1'b0;
        #1 begin ab_we = if1.mem_we; ab_busy = busy1; ab_fail = fail1; ab_err = err1; end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++; if ({busy1, done1, fail1} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {busy1, done1, fail1}); end
        n_tests++; if ({err1, fa1, fe1, fg1} !== '0) begin n_fail++; $display("FAIL reset_results got=%h exp=0", {err1, fa1, fe1, fg1}); end
        n_tests++; if ({if1.mem_we, if1.mem_addr, if1.mem_wdata} !== '0) begin n_fail++; $display("FAIL reset_bus got=%h exp=0", {if1.mem_we, if1.mem_addr, if1.mem_wdata}); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if ({busy1, if1.mem_we, busy2} !== 3'b000) begin n_fail++; $display("FAIL idle_after_reset got=%b exp=000", {busy1, if1.mem_we, busy2}); end
    endtask

    task automatic test_fault_free();
        clear_faults();
        run_bist(8'h5A, 1'b0, 1'b0);
        n_tests++; if (r_lat !== 66) begin n_fail++; $display("FAIL run1_latency got=%0d exp=66", r_lat); end
        n_tests++; if ({r_fail, r_err} !== '0) begin n_fail++; $display("FAIL run1_result got=%b/%0d exp=0/0", r_fail, r_err); end
        n_tests++; if (wn !== 32) begin n_fail++; $display("FAIL run1_write_count got=%0d exp=32", wn); end
        n_tests++; if (wlog[3] !== {4'd3, 8'h59}) begin n_fail++; $display("FAIL run1_w0_addr3 got=%h exp=359", wlog[3]); end
        n_tests++; if (wlog[19] !== {4'd3, 8'hA6}) begin n_fail++; $display("FAIL run1_w1_addr3 got=%h exp=3a6", wlog[19]); end
        n_tests++; if ({r_busy_gap, r_busy_at_done} !== 2'b00) begin n_fail++; $display("FAIL run1_busy got=%b exp=00", {r_busy_gap, r_busy_at_done}); end
    endtask

    task automatic test_stuck0();
        clear_faults();
        sa0[5] = 8'h01;
        run_bist(8'h00, 1'b0, 1'b0);
        n_tests++; if ({r_fail, r_err} !== {1'b1, 6'd1}) begin n_fail++; $display("FAIL run2_count got=%b/%0d exp=1/1", r_fail, r_err); end
        n_tests++; if ({r_fa, r_fe, r_fg} !== {4'd5, 8'h05, 8'h04}) begin n_fail++; $display("FAIL run2_first got=%h exp=50504", {r_fa, r_fe, r_fg}); end
        repeat (5) @(negedge clk);
        n_tests++; if ({fail1, err1, fa1, done1} !== {1'b1, 6'd1, 4'd5, 1'b0}) begin n_fail++; $display("FAIL run2_hold got=%b/%0d/%0d/%b exp=1/1/5/0", fail1, err1, fa1, done1); end
    endtask

    task automatic test_repulse();
        clear_faults();
        sa0[2] = 8'hFF;
        model(8'h3C);
        run_bist(8'h3C, 1'b0, 1'b1);
        n_tests++; if (r_lat !== 66) begin n_fail++; $display("FAIL run3_latency got=%0d exp=66", r_lat); end
        n_tests++; if (r_busy_gap !== 1'b0) begin n_fail++; $display("FAIL run3_busy_gap got=%b exp=0", r_busy_gap); end
        n_tests++; if ({r_err, r_fe, r_fg} !== {6'(m_err), m_fe, m_fg}) begin n_fail++; $display("FAIL run3_seed_kept got=%0d/%h/%h exp=%0d/%h/%h", r_err, r_fe, r_fg, m_err, m_fe, m_fg); end
    endtask

    task automatic test_abort();
        clear_faults();
        abort_run(8'h21, 5);
        n_tests++; if ({ab_pre_we, ab_we, ab_busy} !== 3'b100) begin n_fail++; $display("FAIL run4_w0_abort got=%b exp=100", {ab_pre_we, ab_we, ab_busy}); end
        sa1[0] = 8'h01;
        abort_run(8'h00, 20);
        n_tests++; if ({ab_pre_fail, ab_pre_err} !== {1'b1, 6'd1}) begin n_fail++; $display("FAIL run4_pre_abort got=%b/%0d exp=1/1", ab_pre_fail, ab_pre_err); end
        n_tests++; if ({ab_we, ab_busy, ab_fail, ab_err} !== '0) begin n_fail++; $display("FAIL run4_abort got=%b%b%b/%0d exp=000/0", ab_we, ab_busy, ab_fail, ab_err); end
        clear_faults();
        run_bist(8'hC3, 1'b0, 1'b0);
        n_tests++; if ({r_lat, r_fail, r_err} !== {32'd66, 1'b0, 6'd0}) begin n_fail++; $display("FAIL run4_restart got=%0d/%b/%0d exp=66/0/0", r_lat, r_fail, r_err); end
    endtask

    task automatic test_latency2();
        clear_faults();
        run_bist(8'hFF, 1'b1, 1'b0);
        n_tests++; if (r_lat !== 68) begin n_fail++; $display("FAIL run5_latency got=%0d exp=68", r_lat); end
        n_tests++; if ({r_fail, r_err} !== '0) begin n_fail++; $display("FAIL run5_result got=%b/%0d exp=0/0", r_fail, r_err); end
        lat1 = 2;
        run_bist(8'hFF, 1'b0, 1'b0);
        lat1 = 1;
        n_tests++; if (r_fail !== 1'b1) begin n_fail++; $display("FAIL run5_mismatched_latency got=%b exp=1", r_fail); end
    endtask

    task automatic test_back_to_back();
        clear_faults();
        sa0[3] = 8'h10;
        model(8'h00);
        run_bist(8'h00, 1'b0, 1'b0);
        n_tests++; if ({r_err, r_fa} !== {6'(m_err), m_fa}) begin n_fail++; $display("FAIL run6_first got=%0d/%0d exp=%0d/%0d", r_err, r_fa, m_err, m_fa); end
        start1 = 1'b1; seed1 = 8'h77;
        @(negedge clk);
        start1 = 1'b0;
        n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL run6_done_start got=%b exp=0", busy1); end
        clear_faults();
        for (int i = 0; i < DEPTH; i++) sa1[i] = 8'h80;
        run_bist(8'h00, 1'b0, 1'b0);
        n_tests++; if ({r_fail1, r_err1} !== '0) begin n_fail++; $display("FAIL run6_cleared got=%b/%0d exp=0/0", r_fail1, r_err1); end
        n_tests++; if ({r_fail, r_err} !== {1'b1, 6'd16}) begin n_fail++; $display("FAIL run6_count got=%b/%0d exp=1/16", r_fail, r_err); end
        n_tests++; if ({r_fa, r_fe, r_fg} !== {4'd0, 8'h00, 8'h80}) begin n_fail++; $display("FAIL run6_first_fail got=%h exp=00080", {r_fa, r_fe, r_fg}); end
    endtask

    task automatic test_random();
        logic [DW-1:0] sd, d;
        int a, bad;
        for (int t = 0; t < 6; t++) begin
            clear_faults();
            for (int k = 0; k < 2; k++) begin
                a = $urandom_range(0, DEPTH - 1);
                sa0[a] = DW'($urandom);
                sa1[a] = DW'($urandom) & ~sa0[a];
            end
            sd = DW'($urandom);
            model(sd);
            run_bist(sd, 1'b0, 1'b0);
            bad = 0;
            for (int i = 0; i < 32; i++) begin
                d = DW'(i % DEPTH) ^ sd;
                if (i >= DEPTH) d = ~d;
                if (wlog[i] !== {AW'(i % DEPTH), d}) bad++;
            end
            n_tests++; if ({wn, bad} !== {32'd32, 32'd0}) begin n_fail++; $display("FAIL rand%0d_writes got=%0d/%0d exp=32/0", t, wn, bad); end
            n_tests++; if (r_lat !== 66) begin n_fail++; $display("FAIL rand%0d_latency got=%0d exp=66", t, r_lat); end
            n_tests++; if ({r_fail, r_err} !== {(m_err != 0), 6'(m_err)}) begin n_fail++; $display("FAIL rand%0d_count got=%b/%0d exp=%0d", t, r_fail, r_err, m_err); end
            n_tests++; if ({r_fa, r_fe, r_fg} !== {m_fa, m_fe, m_fg}) begin n_fail++; $display("FAIL rand%0d_first got=%h exp=%h", t, {r_fa, r_fe, r_fg}, {m_fa, m_fe, m_fg}); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start1 = 1'b0; start2 = 1'b0;
        seed1 = '0; seed2 = '0;
        sel2 = 1'b0;
        lat1 = 1;
        clear_faults();
        test_reset();
        test_fault_free();
        test_stuck0();
        test_repulse();
        test_abort();
        test_latency2();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
